// File: rtl/matrix_stream_unloader.sv
// Streams one ROWS x COLS matrix slot out of the matrix buffer on a valid/ready port.
// Optional trailing checksum beat when UNLOAD_CHECKSUM_EN is defined.
module matrix_stream_unloader #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int SLOTS  = 8,
    parameter int ADDR_W = $clog2(SLOTS*ROWS*COLS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       start,
    input  logic [$clog2(SLOTS)-1:0]   slot,
    input  logic                       transpose,
    input  logic                       abort,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [DATA_W-1:0]          rd_data,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int N = ROWS*COLS;
`ifdef UNLOAD_CHECKSUM_EN
    localparam int BEATS = N + 1;
`else
    localparam int BEATS = N;
`endif
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int R_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SLOT_W = $clog2(SLOTS);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                tr_q, tr_d;
    logic [R_W-1:0]      r_q, r_d;
    logic [C_W-1:0]      c_q, c_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                ret_q, ret_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_v_q, hold_v_d;
    logic [DATA_W-1:0]   mem_q [2];
    logic [DATA_W-1:0]   mem_d [2];
    logic                wp_q, wp_d, rp_q, rp_d;
    logic [1:0]          cnt_q, cnt_d;
`ifdef UNLOAD_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                ck_sent_q, ck_sent_d;
`endif

    logic                push, pop, rd_en_c;
    logic [DATA_W-1:0]   push_data;
    logic [2:0]          credit_use;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        tr_d      = tr_q;
        r_d       = r_q;
        c_d       = c_q;
        rd_cnt_d  = rd_cnt_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        mem_d     = mem_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
`ifdef UNLOAD_CHECKSUM_EN
        acc_d     = acc_q;
        ck_sent_d = ck_sent_q;
`endif
        push      = 1'b0;
        push_data = '0;

        // Credit counts this cycle's pop so a steady stream sustains one beat per cycle.
        pop = (state_q == S_STREAM) && enable && !abort && (cnt_q != 2'd0) && out_ready;
        credit_use = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, ret_q} + {2'b0, hold_v_q};
        rd_en_c = (state_q == S_STREAM) && enable && !abort &&
                  (rd_cnt_q < CNT_W'(N)) && (credit_use < 3'd2);
        ret_d = rd_en_c;

        if (!enable) begin
            // A read already issued still returns; park it until enable comes back.
            if (ret_q) begin
                hold_d   = rd_data;
                hold_v_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_STREAM;
                        slot_d    = slot;
                        tr_d      = transpose;
                        r_d       = '0;
                        c_d       = '0;
                        rd_cnt_d  = '0;
                        beat_d    = '0;
`ifdef UNLOAD_CHECKSUM_EN
                        acc_d     = '0;
                        ck_sent_d = 1'b0;
`endif
                    end
                end
                S_STREAM, S_DONE: begin
                    if (abort) begin
                        state_d   = S_IDLE;
                        r_d       = '0;
                        c_d       = '0;
                        rd_cnt_d  = '0;
                        beat_d    = '0;
                        hold_v_d  = 1'b0;
                        wp_d      = 1'b0;
                        rp_d      = 1'b0;
                        cnt_d     = 2'd0;
`ifdef UNLOAD_CHECKSUM_EN
                        acc_d     = '0;
                        ck_sent_d = 1'b0;
`endif
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end else begin
                        if (ret_q) begin
                            push      = 1'b1;
                            push_data = rd_data;
                        end else if (hold_v_q) begin
                            push      = 1'b1;
                            push_data = hold_q;
                            hold_v_d  = 1'b0;
                        end
`ifdef UNLOAD_CHECKSUM_EN
                        if (push) begin
                            acc_d = acc_q + push_data;
                        end else if ((rd_cnt_q == CNT_W'(N)) && !ck_sent_q &&
                                     ((cnt_q - {1'b0, pop}) < 2'd2)) begin
                            push      = 1'b1;
                            push_data = acc_q;
                            ck_sent_d = 1'b1;
                        end
`endif
                        if (rd_en_c) begin
                            rd_cnt_d = rd_cnt_q + CNT_W'(1);
                            if (!tr_q) begin
                                if (c_q == C_W'(COLS-1)) begin
                                    c_d = '0;
                                    r_d = (r_q == R_W'(ROWS-1)) ? '0 : r_q + R_W'(1);
                                end else begin
                                    c_d = c_q + C_W'(1);
                                end
                            end else begin
                                if (r_q == R_W'(ROWS-1)) begin
                                    r_d = '0;
                                    c_d = (c_q == C_W'(COLS-1)) ? '0 : c_q + C_W'(1);
                                end else begin
                                    r_d = r_q + R_W'(1);
                                end
                            end
                        end
                        if (push) begin
                            mem_d[wp_q] = push_data;
                            wp_d        = ~wp_q;
                        end
                        if (pop) begin
                            rp_d   = ~rp_q;
                            beat_d = beat_q + CNT_W'(1);
                            if (beat_q == CNT_W'(BEATS-1)) begin
                                state_d = S_DONE;
                                beat_d  = '0;
                            end
                        end
                        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            tr_q      <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            rd_cnt_q  <= '0;
            beat_q    <= '0;
            ret_q     <= 1'b0;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= 2'd0;
`ifdef UNLOAD_CHECKSUM_EN
            acc_q     <= '0;
            ck_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            tr_q      <= tr_d;
            r_q       <= r_d;
            c_q       <= c_d;
            rd_cnt_q  <= rd_cnt_d;
            beat_q    <= beat_d;
            ret_q     <= ret_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            mem_q     <= mem_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
`ifdef UNLOAD_CHECKSUM_EN
            acc_q     <= acc_d;
            ck_sent_q <= ck_sent_d;
`endif
        end
    end

    assign rd_en     = rd_en_c;
    assign rd_addr   = ADDR_W'(slot_q) * ADDR_W'(N) + ADDR_W'(r_q) * ADDR_W'(COLS) + ADDR_W'(c_q);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign out_last  = out_valid && (beat_q == CNT_W'(BEATS-1));
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
